// File: rtl/memaccess_ctrl_pkg.sv
// Shared types and constants for the LC-3 MemAccess-stage sequencer.
package memaccess_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IND,
        RD,
        WR
    } state_e;

    localparam logic [1:0] MS_READ  = 2'd0;
    localparam logic [1:0] MS_WRITE = 2'd1;
    localparam logic [1:0] MS_IND   = 2'd2;
    localparam logic [1:0] MS_IDLE  = 2'd3;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    // First access state for an accepted opcode; IDLE marks a non-memory opcode.
    function automatic state_e first_state(input logic [3:0] op);
        state_e s;
        case (op)
            OP_LD, OP_LDR: s = RD;
            OP_ST, OP_STR: s = WR;
            OP_LDI, OP_STI: s = IND;
            default:       s = IDLE;
        endcase
        return s;
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic [1:0] ms_encode(input state_e s);
        logic [1:0] ms;
        case (s)
            IND:     ms = MS_IND;
            RD:      ms = MS_READ;
            WR:      ms = MS_WRITE;
            default: ms = MS_IDLE;
        endcase
        return ms;
    endfunction

endpackage

// File: rtl/memaccess_ctrl_if.sv
// Handshake bundle between the pipeline controller, the sequencer and data memory.
interface memaccess_ctrl_if;
    logic       mem_req;
    logic [3:0] opcode;
    logic       dmem_ready;
    logic [1:0] mem_state;
    logic       M_Control;
    logic       dmem_rd;
    logic       dmem_we;
    logic       stall;
    logic       mem_done;
    logic       err_illegal;
    logic       err_timeout;

    modport master (
        output mem_req, opcode, dmem_ready,
        input  mem_state, M_Control, dmem_rd, dmem_we, stall,
               mem_done, err_illegal, err_timeout
    );

    modport slave (
        input  mem_req, opcode, dmem_ready,
        output mem_state, M_Control, dmem_rd, dmem_we, stall,
               mem_done, err_illegal, err_timeout
    );
endinterface

// File: rtl/memaccess_wait_timer.sv
// Per-phase wait-state counter; expire fires on the TIMEOUT-th consecutive not-ready cycle.
module memaccess_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Ready in the limit cycle drops en, so completion always beats expiry.
    assign expire = en && (cnt_q == LIMIT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/memaccess_ctrl.sv
// MemAccess-stage sequencer: walks direct and indirect loads/stores through data memory.
module memaccess_ctrl
    import memaccess_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic            clock,
    input  logic            reset,
    memaccess_ctrl_if.slave bus
);
    state_e     state_q, state_d;
    state_e     accept_state;
    logic       is_store_q, is_store_d;
    logic [1:0] mem_state_q, mem_state_d;
    logic       m_control_q, m_control_d;
    logic       dmem_rd_q, dmem_rd_d;
    logic       dmem_we_q, dmem_we_d;
    logic       stall_q, stall_d;
    logic       mem_done_q, mem_done_d;
    logic       err_illegal_q, err_illegal_d;
    logic       err_timeout_q, err_timeout_d;
    logic       wait_en, wait_clr, wait_expire;

    assign accept_state = first_state(bus.opcode);
    assign wait_en      = (state_q != IDLE) && !bus.dmem_ready;
    assign wait_clr     = (state_d != state_q);

    memaccess_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clock  (clock),
        .reset  (reset),
        .clr    (wait_clr),
        .en     (wait_en),
        .expire (wait_expire)
    );

    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        m_control_d   = m_control_q;
        mem_done_d    = 1'b0;
        err_illegal_d = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                // The done cycle blocks acceptance, leaving a one-cycle gap.
                if (bus.mem_req && !mem_done_q) begin
                    state_d       = accept_state;
                    is_store_d    = op_is_store(bus.opcode);
                    err_illegal_d = (accept_state == IDLE);
                end
            end
            IND: begin
                if (bus.dmem_ready) begin
                    state_d     = is_store_q ? WR : RD;
                    m_control_d = 1'b1;
                end else if (wait_expire) begin
                    state_d       = IDLE;
                    mem_done_d    = 1'b1;
                    err_timeout_d = 1'b1;
                end
            end
            RD, WR: begin
                if (bus.dmem_ready) begin
                    state_d    = IDLE;
                    mem_done_d = 1'b1;
                end else if (wait_expire) begin
                    state_d       = IDLE;
                    mem_done_d    = 1'b1;
                    err_timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE || state_d == IND) begin
            m_control_d = 1'b0;
        end
        mem_state_d = ms_encode(state_d);
        dmem_rd_d   = (state_d == IND) || (state_d == RD);
        dmem_we_d   = (state_d == WR);
        stall_d     = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            is_store_q    <= 1'b0;
            mem_state_q   <= MS_IDLE;
            m_control_q   <= 1'b0;
            dmem_rd_q     <= 1'b0;
            dmem_we_q     <= 1'b0;
            stall_q       <= 1'b0;
            mem_done_q    <= 1'b0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_store_q    <= is_store_d;
            mem_state_q   <= mem_state_d;
            m_control_q   <= m_control_d;
            dmem_rd_q     <= dmem_rd_d;
            dmem_we_q     <= dmem_we_d;
            stall_q       <= stall_d;
            mem_done_q    <= mem_done_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.mem_state   = mem_state_q;
    assign bus.M_Control   = m_control_q;
    assign bus.dmem_rd     = dmem_rd_q;
    assign bus.dmem_we     = dmem_we_q;
    assign bus.stall       = stall_q;
    assign bus.mem_done    = mem_done_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_memaccess_ctrl.sv
// Randomized bench for memaccess_ctrl: a per-phase latency model predicts every output cycle.
module tb_memaccess_ctrl;
    localparam int TO = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    memaccess_ctrl_if bus();

    memaccess_ctrl #(.TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] ms;
        logic       mc;
        logic       rd;
        logic       we;
        logic       st;
        logic       dn;
        logic       il;
        logic       to;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic out_t quiet(input logic dn, input logic il, input logic to);
        out_t o;
        o.ms = 2'd3; o.mc = 1'b0; o.rd = 1'b0; o.we = 1'b0; o.st = 1'b0;
        o.dn = dn;   o.il = il;   o.to = to;
        return o;
    endfunction

    // Outputs while a memory phase is in flight, derived from the mem_state code.
    function automatic out_t busy(input logic [1:0] ms, input logic mc);
        out_t o;
        o.ms = ms; o.mc = mc;
        o.rd = (ms == 2'd0) || (ms == 2'd2);
        o.we = (ms == 2'd1);
        o.st = 1'b1; o.dn = 1'b0; o.il = 1'b0; o.to = 1'b0;
        return o;
    endfunction

    function automatic void check_lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endfunction

    // Drive one cycle of inputs and record what the outputs must be after the next edge.
    task automatic step(input logic rst, input logic req, input logic [3:0] op,
                        input logic rdy, input out_t e);
        @(negedge clock);
        reset          = rst;
        bus.mem_req    = req;
        bus.opcode     = op;
        bus.dmem_ready = rdy;
        exp_q.push_back(e);
    endtask

    // A phase with w not-ready cycles lasts w+1 cycles, or TO cycles and times out if w >= TO.
    task automatic do_phase(input logic [3:0] op, input int w, input out_t here,
                            input out_t succ, output logic ok, inout int n);
        if (w >= TO) begin
            for (int i = 0; i < TO - 1; i++) begin
                step(1'b1, 1'b1, op, 1'b0, here);
                n++;
            end
            step(1'b1, 1'b1, op, 1'b0, quiet(1'b1, 1'b0, 1'b1));
            n++;
            ok = 1'b0;
        end else begin
            for (int i = 0; i < w; i++) begin
                step(1'b1, 1'b1, op, 1'b0, here);
                n++;
            end
            step(1'b1, 1'b1, op, 1'b1, succ);
            n++;
            ok = 1'b1;
        end
    endtask

    // Runs one request; lat is the cycle index (acceptance = 0) of mem_done or err_illegal.
    task automatic run_txn(input logic [3:0] op, input int w1, input int w2, output int lat);
        int   n;
        logic ok;
        out_t second;
        n = 0;
        if (op inside {4'b0010, 4'b0110}) begin
            step(1'b1, 1'b1, op, 1'($urandom_range(0, 1)), busy(2'd0, 1'b0));
            n = 1;
            do_phase(op, w1, busy(2'd0, 1'b0), quiet(1'b1, 1'b0, 1'b0), ok, n);
        end else if (op inside {4'b0011, 4'b0111}) begin
            step(1'b1, 1'b1, op, 1'($urandom_range(0, 1)), busy(2'd1, 1'b0));
            n = 1;
            do_phase(op, w1, busy(2'd1, 1'b0), quiet(1'b1, 1'b0, 1'b0), ok, n);
        end else if (op inside {4'b1010, 4'b1011}) begin
            second = (op == 4'b1011) ? busy(2'd1, 1'b1) : busy(2'd0, 1'b1);
            step(1'b1, 1'b1, op, 1'($urandom_range(0, 1)), busy(2'd2, 1'b0));
            n = 1;
            do_phase(op, w1, busy(2'd2, 1'b0), second, ok, n);
            if (ok) begin
                do_phase(op, w2, second, quiet(1'b1, 1'b0, 1'b0), ok, n);
            end
        end else begin
            step(1'b1, 1'b1, op, 1'($urandom_range(0, 1)), quiet(1'b0, 1'b1, 1'b0));
            lat = 1;
            step(1'b1, 1'b0, 4'($urandom), 1'($urandom_range(0, 1)), quiet(1'b0, 1'b0, 1'b0));
            return;
        end
        lat = n;
        // Request still high during the done cycle must be ignored.
        step(1'b1, 1'b1, 4'($urandom), 1'($urandom_range(0, 1)), quiet(1'b0, 1'b0, 1'b0));
    endtask

    initial begin : compare
        out_t e;
        out_t got;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.mem_state, bus.M_Control, bus.dmem_rd, bus.dmem_we, bus.stall,
                       bus.mem_done, bus.err_illegal, bus.err_timeout};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got ms=%0d mc=%b rd=%b we=%b stall=%b done=%b ill=%b tmo=%b, want ms=%0d mc=%b rd=%b we=%b stall=%b done=%b ill=%b tmo=%b",
                             cyc, got.ms, got.mc, got.rd, got.we, got.st, got.dn, got.il, got.to,
                             e.ms, e.mc, e.rd, e.we, e.st, e.dn, e.il, e.to);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin : stim
        int         lat;
        int         w1, w2;
        logic [3:0] op;
        logic [3:0] legal [6];
        legal[0] = 4'b0010; legal[1] = 4'b0110; legal[2] = 4'b1010;
        legal[3] = 4'b0011; legal[4] = 4'b0111; legal[5] = 4'b1011;

        bus.mem_req    = 1'b0;
        bus.opcode     = 4'b0000;
        bus.dmem_ready = 1'b0;

        // Reset held with a pending request.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'b0010, 1'($urandom_range(0, 1)), quiet(1'b0, 1'b0, 1'b0));
        end

        run_txn(4'b0010, 0, 0, lat);
        check_lit("ld_latency", lat, 2);
        run_txn(4'b1011, 2, 0, lat);
        check_lit("sti_wait_latency", lat, 5);
        run_txn(4'b1010, 0, 0, lat);
        check_lit("ldi_latency", lat, 3);
        run_txn(4'b0001, 0, 0, lat);
        check_lit("illegal_latency", lat, 1);
        run_txn(4'b0011, 100, 0, lat);
        check_lit("st_timeout_latency", lat, TO + 1);
        run_txn(4'b0011, TO - 1, 0, lat);
        check_lit("st_late_ready_latency", lat, TO + 1);

        // Reset during the RD phase of an LDI drops the access silently.
        step(1'b1, 1'b1, 4'b1010, 1'b0, busy(2'd2, 1'b0));
        step(1'b1, 1'b1, 4'b1010, 1'b1, busy(2'd0, 1'b1));
        step(1'b0, 1'b1, 4'b1010, 1'b0, quiet(1'b0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b1010, 1'b0, quiet(1'b0, 1'b0, 1'b0));
        run_txn(4'b0010, 1, 0, lat);
        check_lit("ld_after_reset_latency", lat, 3);

        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 9) < 8) op = legal[$urandom_range(0, 5)];
            else                          op = 4'($urandom);
            case ($urandom_range(0, 5))
                0:       w1 = TO - 1;
                1:       w1 = TO + $urandom_range(0, 2);
                default: w1 = $urandom_range(0, 2);
            endcase
            case ($urandom_range(0, 5))
                0:       w2 = TO - 1;
                1:       w2 = TO;
                default: w2 = $urandom_range(0, 2);
            endcase
            run_txn(op, w1, w2, lat);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                step(1'b1, 1'b0, 4'($urandom), 1'($urandom_range(0, 1)), quiet(1'b0, 1'b0, 1'b0));
            end
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clock);
        end
        @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memaccess_ctrl.md
# memaccess_ctrl

Sequencer for the LC-3 pipeline's MemAccess stage: decodes the memory opcode held in the stage and drives `mem_state` and `M_Control` across one or two data-memory accesses. It handles direct loads and stores, indirect (LDI/STI) two-phase accesses, memory wait-states, and timeout recovery. It asserts `stall` to freeze upstream stages while an access is in flight. It sits between the pipeline controller and the MemAccess datapath/data memory.

## Interface
- TIMEOUT, default 16: max consecutive not-ready cycles per access phase before abort (≥2).
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- mem_req  in  1  MemAccess stage holds a valid instruction; held high until `mem_done`.
- opcode  in  4  IR[15:12] of that instruction; sampled only at acceptance.
- dmem_ready  in  1  data memory completes the current read/write this cycle.
- mem_state  out  2  0=read, 1=write, 2=indirect-address read, 3=idle.
- M_Control  out  1  address select: 0=M_Addr, 1=DMem_dout (indirect pointer).
- dmem_rd  out  1  data-memory read enable.
- dmem_we  out  1  data-memory write enable.
- stall  out  1  freeze fetch/decode/execute.
- mem_done  out  1  one-cycle pulse: access sequence finished.
- err_illegal  out  1  one-cycle pulse: `mem_req` with non-memory opcode.
- err_timeout  out  1  one-cycle pulse: phase aborted after TIMEOUT not-ready cycles.

## Operation
- States:
  - IDLE: mem_state=3.
  - IND: mem_state=2, M_Control=0, dmem_rd=1.
  - RD: mem_state=0, dmem_rd=1.
  - WR: mem_state=1, dmem_we=1.
  - In RD/WR, M_Control = 1 if entered from IND, else 0.
- Acceptance happens in IDLE with `mem_req`=1 and `mem_done`=0. Opcode is latched and the next state is chosen:
  - LD 0010 or LDR 0110 → RD.
  - ST 0011 or STR 0111 → WR.
  - LDI 1010 or STI 1011 → IND.
  - Any other opcode → remain IDLE, pulse `err_illegal` next cycle, no stall.
- IND with `dmem_ready`=1 → RD (LDI) or WR (STI), with M_Control=1.
- RD/WR with `dmem_ready`=1 → IDLE, with `mem_done`=1 in the IDLE cycle.
- Wait counter (width clog2(TIMEOUT+1)):
  - Cleared on each state entry.
  - Increments each access-state cycle with `dmem_ready`=0.
  - If it reaches TIMEOUT-1 while `dmem_ready`=0 → IDLE, with `err_timeout`=1 and `mem_done`=1 in the IDLE cycle. An indirect sequence is abandoned.
- `stall`=1 in every non-IDLE state; 0 in IDLE.
- `mem_req` is ignored during the `mem_done` cycle, so back-to-back accesses have a one-cycle idle gap.

## Timing
- All outputs are registered (decoded from state/flag flops); no combinational input-to-output paths.
- Reset values: mem_state=3, M_Control=0, dmem_rd=0, dmem_we=0, stall=0, mem_done=0, err_illegal=0, err_timeout=0. Counter=0, state=IDLE.
- Latency with zero wait-states, req sampled at cycle 0:
  - LD/ST: access in cycle 1, `mem_done` in cycle 2.
  - LDI/STI: IND in cycle 1, RD/WR in cycle 2, `mem_done` in cycle 3.
  - Each wait-state adds one cycle per phase.
- `dmem_ready` is only meaningful in access states; it is ignored in IDLE.
- Reset asserted mid-sequence: the next edge forces reset values and the access is dropped. No `mem_done` or error pulse.
- `dmem_ready`=1 in the same cycle the counter hits TIMEOUT-1: completion wins, no error.

## Structure
- `memaccess_ctrl_pkg`:
  - state enum {IDLE, IND, RD, WR}.
  - mem_state encodings MS_READ=0, MS_WRITE=1, MS_IND=2, MS_IDLE=3.
  - opcode constants OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI.
- One sub-module: `memaccess_wait_timer`, the per-phase wait counter with clear/enable inputs and an expire output.

## Test plan
- Reset: hold reset=0 for 3 cycles with mem_req=1 → mem_state=3, all other outputs 0.
- LD 0010, dmem_ready=1 → cycle 1: mem_state=0, dmem_rd=1, stall=1, M_Control=0; cycle 2: mem_done=1, mem_state=3.
- STI 1011, ready low 2 cycles in IND, then high → 3 cycles of mem_state=2 with M_Control=0; then mem_state=1, dmem_we=1, M_Control=1; `mem_done` one cycle after ready.
- Opcode 0001 (ADD) with mem_req=1 → err_illegal pulse next cycle, stall=0, mem_state stays 3.
- TIMEOUT=4, ST with dmem_ready=0 forever → mem_state=1 for 4 cycles, then err_timeout=1, mem_done=1, mem_state=3. A second case with ready=1 on the 4th cycle → done, no error.
- LDI, reset=0 asserted during RD phase → next cycle all outputs at reset values, no mem_done pulse; a following LD completes normally.
